// File: rtl/misc_exec_buf_if.sv
// rtl/misc_exec_buf_if.sv - op encoding and issue/result handshake bundle for misc_exec_buf
package misc_exec_buf_pkg;
    typedef enum logic [3:0] {
        INSTR_JAL,
        INSTR_JALR,
        INSTR_LUI,
        INSTR_AUIPC,
        INSTR_BEQ,
        INSTR_BNE,
        INSTR_BLT,
        INSTR_BGE,
        INSTR_BLTU,
        INSTR_BGEU,
        INSTR_INVAL
    } instr_op;
endpackage

interface misc_exec_buf_if
    import misc_exec_buf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    instr_op          in_op;
    logic [XLEN-1:0]  in_pc;
    logic             in_len2;
    logic [XLEN-1:0]  in_rs1_val;
    logic [XLEN-1:0]  in_rs2_val;
    logic [XLEN-1:0]  in_imm;
    logic [REG_W-1:0] in_rd;

    logic             out_valid;
    logic             out_ready;
    logic [REG_W-1:0] out_rd_idx;
    logic [XLEN-1:0]  out_rd_val;
    logic             out_br_valid;
    logic [XLEN-1:0]  out_br_target;
    logic             out_exc_valid;
    logic [1:0]       out_exc_cause;

    modport master (
        output in_valid, in_op, in_pc, in_len2, in_rs1_val, in_rs2_val, in_imm, in_rd, out_ready,
        input  in_ready, out_valid, out_rd_idx, out_rd_val, out_br_valid, out_br_target,
               out_exc_valid, out_exc_cause
    );

    modport slave (
        input  in_valid, in_op, in_pc, in_len2, in_rs1_val, in_rs2_val, in_imm, in_rd, out_ready,
        output in_ready, out_valid, out_rd_idx, out_rd_val, out_br_valid, out_br_target,
               out_exc_valid, out_exc_cause
    );
endinterface

// File: rtl/misc_exec_buf.sv
// rtl/misc_exec_buf.sv - jump/branch/upper-immediate execution unit with a DEPTH-entry result queue
module misc_exec_buf
    import misc_exec_buf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int C_EXT = 0,
    parameter int REG_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    misc_exec_buf_if.slave bus
);

    typedef struct packed {
        logic [REG_W-1:0] rd_idx;
        logic [XLEN-1:0]  rd_val;
        logic             br_valid;
        logic [XLEN-1:0]  br_target;
        logic [1:0]       exc_cause;
    } entry_t;

    entry_t          mem [4];
    entry_t          res;
    entry_t          head;
    logic [2:0]      count;
    logic [1:0]      wr_ptr;
    logic [1:0]      rd_ptr;
    logic            push;
    logic            pop;
    logic            out_valid_int;

    logic [XLEN-1:0] ilen;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            taken;
    logic            is_branch;
    logic [1:0]      cause;

    always_comb begin
        ilen      = ((C_EXT != 0) && bus.in_len2) ? XLEN'(2) : XLEN'(4);
        link      = bus.in_pc + ilen;
        pc_imm    = bus.in_pc + bus.in_imm;
        jalr_tgt  = (bus.in_rs1_val + bus.in_imm) & ~XLEN'(1);
        redirect  = 1'b0;
        taken     = 1'b0;
        is_branch = 1'b0;
        cause     = 2'd0;
        target    = link;
        res       = '0;
        res.rd_idx = bus.in_rd;
        res.rd_val = link;
        case (bus.in_op)
            INSTR_JAL:   begin redirect = 1'b1; target = pc_imm; end
            INSTR_JALR:  begin redirect = 1'b1; target = jalr_tgt; end
            INSTR_LUI:   res.rd_val = bus.in_imm;
            INSTR_AUIPC: res.rd_val = pc_imm;
            INSTR_BEQ:   begin is_branch = 1'b1; taken = (bus.in_rs1_val == bus.in_rs2_val); end
            INSTR_BNE:   begin is_branch = 1'b1; taken = (bus.in_rs1_val != bus.in_rs2_val); end
            INSTR_BLT:   begin is_branch = 1'b1; taken = ($signed(bus.in_rs1_val) <  $signed(bus.in_rs2_val)); end
            INSTR_BGE:   begin is_branch = 1'b1; taken = ($signed(bus.in_rs1_val) >= $signed(bus.in_rs2_val)); end
            INSTR_BLTU:  begin is_branch = 1'b1; taken = (bus.in_rs1_val <  bus.in_rs2_val); end
            INSTR_BGEU:  begin is_branch = 1'b1; taken = (bus.in_rs1_val >= bus.in_rs2_val); end
            default:     begin cause = 2'd1; target = bus.in_pc; res.rd_val = '0; end
        endcase
        // Branches never write back; a not-taken branch reports the fall-through PC.
        if (is_branch) begin
            res.rd_idx = '0;
            res.rd_val = '0;
            redirect   = taken;
            target     = taken ? pc_imm : link;
        end
        if (redirect && (C_EXT == 0) && target[1]) begin
            cause    = 2'd2;
            redirect = 1'b0;
        end
        if (cause != 2'd0) begin
            res.rd_idx = '0;
        end
        res.br_valid  = redirect;
        res.br_target = target;
        res.exc_cause = cause;
    end

    assign out_valid_int = (count != 3'd0);
    assign bus.in_ready  = (count < 3'(DEPTH)) || bus.out_ready;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = out_valid_int && bus.out_ready;
    assign head          = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= 3'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else if (flush) begin
            count  <= 3'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == 2'(DEPTH - 1)) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'(DEPTH - 1)) ? 2'd0 : rd_ptr + 2'd1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    // Payload needs no reset: every output field is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res;
        end
    end

    assign bus.out_valid     = out_valid_int;
    assign bus.out_rd_idx    = out_valid_int ? head.rd_idx    : '0;
    assign bus.out_rd_val    = out_valid_int ? head.rd_val    : '0;
    assign bus.out_br_valid  = out_valid_int && head.br_valid;
    assign bus.out_br_target = out_valid_int ? head.br_target : '0;
    assign bus.out_exc_cause = out_valid_int ? head.exc_cause : 2'd0;
    assign bus.out_exc_valid = out_valid_int && (head.exc_cause != 2'd0);

endmodule

// File: tb/tb_misc_exec_buf.sv
// tb/tb_misc_exec_buf.sv - directed scoreboard bench for misc_exec_buf (C_EXT=0 and C_EXT=1 instances)
module tb_misc_exec_buf;
    import misc_exec_buf_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        br;
        logic [31:0] tgt;
        logic [1:0]  cause;
        bit          cv;
        bit          ct;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    misc_exec_buf_if #(.XLEN(32), .REG_W(5)) if0 ();
    misc_exec_buf_if #(.XLEN(32), .REG_W(5)) if1 ();

    misc_exec_buf #(.XLEN(32), .DEPTH(2), .C_EXT(0), .REG_W(5)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if0)
    );
    misc_exec_buf #(.XLEN(32), .DEPTH(2), .C_EXT(1), .REG_W(5)) dut1 (
        .clk(clk), .rst(rst), .flush(1'b0), .bus(if1)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] val, input logic br,
                                input logic [31:0] tgt, input logic [1:0] cause, input bit cv, input bit ct);
        exp_t e;
        e.rd = rd; e.val = val; e.br = br; e.tgt = tgt; e.cause = cause; e.cv = cv; e.ct = ct;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [4:0] rd, input logic [31:0] val,
                       input logic br, input logic [31:0] tgt, input logic [1:0] cause, input logic exc);
        chk({tag, ".rd_idx"}, 32'(rd), 32'(e.rd));
        chk({tag, ".br_valid"}, 32'(br), 32'(e.br));
        chk({tag, ".exc_cause"}, 32'(cause), 32'(e.cause));
        chk({tag, ".exc_valid"}, 32'(exc), 32'(e.cause != 2'd0));
        if (e.cv) chk({tag, ".rd_val"}, val, e.val);
        if (e.ct) chk({tag, ".br_target"}, tgt, e.tgt);
    endtask

    always @(negedge clk) begin
        if (rst && if0.out_valid && if0.out_ready) begin
            checks++;
            assert (q0.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out0: observed rd_val 0x%0h expected no result", if0.out_rd_val);
            end
            if (q0.size() != 0)
                cmp("dut0", q0.pop_front(), if0.out_rd_idx, if0.out_rd_val, if0.out_br_valid,
                    if0.out_br_target, if0.out_exc_cause, if0.out_exc_valid);
        end
        if (rst && if1.out_valid && if1.out_ready) begin
            checks++;
            assert (q1.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out1: observed rd_val 0x%0h expected no result", if1.out_rd_val);
            end
            if (q1.size() != 0)
                cmp("dut1", q1.pop_front(), if1.out_rd_idx, if1.out_rd_val, if1.out_br_valid,
                    if1.out_br_target, if1.out_exc_cause, if1.out_exc_valid);
        end
    end

    task automatic drive(input bit w, input instr_op op, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd, input logic len2);
        if (!w) begin
            if0.in_valid = 1'b1; if0.in_op = op; if0.in_pc = pc; if0.in_rs1_val = rs1;
            if0.in_rs2_val = rs2; if0.in_imm = imm; if0.in_rd = rd; if0.in_len2 = len2;
        end else begin
            if1.in_valid = 1'b1; if1.in_op = op; if1.in_pc = pc; if1.in_rs1_val = rs1;
            if1.in_rs2_val = rs2; if1.in_imm = imm; if1.in_rd = rd; if1.in_len2 = len2;
        end
    endtask

    task automatic idle();
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
    endtask

    task automatic send(input bit w, input instr_op op, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd,
                        input logic len2, input exp_t e);
        int   n = 0;
        logic rdy;
        drive(w, op, pc, rs1, rs2, imm, rd, len2);
        do begin
            @(negedge clk);
            rdy = w ? if1.in_ready : if0.in_ready;
            n++;
        end while (!rdy && n < 50);
        chk("accept_in_time", 32'(rdy), 32'd1);
        if (w) q1.push_back(e); else q0.push_back(e);
        @(posedge clk);
        #1 idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.in_valid = 0; if0.in_op = INSTR_LUI; if0.in_pc = 0; if0.in_len2 = 0; if0.in_rs1_val = 0;
        if0.in_rs2_val = 0; if0.in_imm = 0; if0.in_rd = 0; if0.out_ready = 0;
        if1.in_valid = 0; if1.in_op = INSTR_LUI; if1.in_pc = 0; if1.in_len2 = 0; if1.in_rs1_val = 0;
        if1.in_rs2_val = 0; if1.in_imm = 0; if1.in_rd = 0; if1.out_ready = 1;

        // reset state
        #12;
        chk("reset_out_valid", 32'(if0.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(if0.in_ready), 32'd1);
        chk("post_reset_out_valid", 32'(if0.out_valid), 32'd0);
        chk("post_reset_rd_val", if0.out_rd_val, 32'd0);
        @(posedge clk);
        #1 if0.out_ready = 1'b1;

        // JALR with latency check
        send(0, INSTR_JALR, 32'h100, 32'h2001, 32'h0, 32'h4, 5'd1, 1'b0,
             mk(5'd1, 32'h104, 1'b1, 32'h2004, 2'd0, 1, 1));
        chk("jalr_latency", 32'(if0.out_valid), 32'd1);
        @(posedge clk); #1;

        // branches
        send(0, INSTR_BLT, 32'h40, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 5'd5, 1'b0,
             mk(5'd0, 32'h0, 1'b1, 32'h38, 2'd0, 0, 1));
        send(0, INSTR_BLTU, 32'h40, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 5'd5, 1'b0,
             mk(5'd0, 32'h0, 1'b0, 32'h44, 2'd0, 0, 1));
        send(0, INSTR_BEQ, 32'h200, 32'h5, 32'h5, 32'h10, 5'd6, 1'b0,
             mk(5'd0, 32'h0, 1'b1, 32'h210, 2'd0, 0, 1));
        send(0, INSTR_BGEU, 32'h200, 32'h1, 32'hFFFF_FFFF, 32'h10, 5'd6, 1'b0,
             mk(5'd0, 32'h0, 1'b0, 32'h204, 2'd0, 0, 1));
        send(0, INSTR_AUIPC, 32'h1000, 32'h0, 32'h0, 32'hFFFF_F000, 5'd3, 1'b0,
             mk(5'd3, 32'h0, 1'b0, 32'h0, 2'd0, 1, 0));
        repeat (2) @(posedge clk); #1;

        // backpressure with DEPTH=2
        if0.out_ready = 1'b0;
        drive(0, INSTR_LUI, 32'h0, 32'h0, 32'h0, 32'h1000, 5'd2, 1'b0);
        q0.push_back(mk(5'd2, 32'h1000, 1'b0, 32'h0, 2'd0, 1, 0));
        @(posedge clk);
        #1 drive(0, INSTR_LUI, 32'h0, 32'h0, 32'h0, 32'h2000, 5'd2, 1'b0);
        q0.push_back(mk(5'd2, 32'h2000, 1'b0, 32'h0, 2'd0, 1, 0));
        @(posedge clk);
        #1 drive(0, INSTR_LUI, 32'h0, 32'h0, 32'h0, 32'h3000, 5'd2, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(if0.in_ready), 32'd0);
        @(negedge clk);
        chk("full_in_ready_hold", 32'(if0.in_ready), 32'd0);
        chk("stalled_head_stable", if0.out_rd_val, 32'h1000);
        @(posedge clk);
        #1 if0.out_ready = 1'b1;
        q0.push_back(mk(5'd2, 32'h3000, 1'b0, 32'h0, 2'd0, 1, 0));
        @(negedge clk);
        chk("pop_cycle_in_ready", 32'(if0.in_ready), 32'd1);
        @(posedge clk);
        #1 idle();
        repeat (4) @(posedge clk); #1;
        chk("drained_out_valid", 32'(if0.out_valid), 32'd0);

        // misaligned target vs compressed
        send(0, INSTR_JAL, 32'h10, 32'h0, 32'h0, 32'h6, 5'd1, 1'b0,
             mk(5'd0, 32'h0, 1'b0, 32'h0, 2'd2, 0, 0));
        send(1, INSTR_JAL, 32'h10, 32'h0, 32'h0, 32'h6, 5'd1, 1'b1,
             mk(5'd1, 32'h12, 1'b1, 32'h16, 2'd0, 1, 1));
        send(0, INSTR_INVAL, 32'h80, 32'h0, 32'h0, 32'h0, 5'd7, 1'b0,
             mk(5'd0, 32'h0, 1'b0, 32'h80, 2'd1, 1, 1));
        repeat (3) @(posedge clk); #1;

        // flush with two queued entries, a pop and a simultaneous input
        if0.out_ready = 1'b0;
        drive(0, INSTR_LUI, 32'h0, 32'h0, 32'h0, 32'h11, 5'd4, 1'b0);
        @(posedge clk);
        #1 drive(0, INSTR_LUI, 32'h0, 32'h0, 32'h0, 32'h22, 5'd4, 1'b0);
        @(posedge clk);
        #1 drive(0, INSTR_LUI, 32'h0, 32'h0, 32'h0, 32'h33, 5'd4, 1'b0);
        if0.out_ready = 1'b1;
        flush = 1'b1;
        q0.push_back(mk(5'd4, 32'h11, 1'b0, 32'h0, 2'd0, 1, 0));
        @(posedge clk);
        #1 flush = 1'b0;
        idle();
        chk("flush_out_valid", 32'(if0.out_valid), 32'd0);
        chk("flush_in_ready", 32'(if0.in_ready), 32'd1);
        repeat (3) @(posedge clk); #1;
        chk("flush_stays_empty", 32'(if0.out_valid), 32'd0);

        // asynchronous reset mid-stream
        if0.out_ready = 1'b0;
        drive(0, INSTR_LUI, 32'h0, 32'h0, 32'h0, 32'h44, 5'd4, 1'b0);
        @(posedge clk);
        #1 idle();
        chk("pre_reset_valid", 32'(if0.out_valid), 32'd1);
        #2 rst = 1'b0;
        #1 chk("async_reset_valid", 32'(if0.out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        if0.out_ready = 1'b1;
        @(negedge clk);
        chk("reset_release_in_ready", 32'(if0.in_ready), 32'd1);
        repeat (3) @(posedge clk); #1;

        chk("scoreboard0_empty", 32'(q0.size()), 32'd0);
        chk("scoreboard1_empty", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/misc_exec_buf.md
Name: misc_exec_buf

Overview:
- Parametrised successor to the single-cycle misc execution unit.
- Handles JAL, JALR, LUI, AUIPC, the six conditional branches, and invalid-instruction exception reporting.
- Results go into a registered DEPTH-entry output queue with valid/ready backpressure, so a stalled writeback/commit stage never forces recomputation.
- Sits between the issue stage (decoupled input) and the writeback/branch-resolve stage.

Parameters:
- XLEN, 32: data/address width.
- DEPTH, 2: output queue entries (1..4).
- C_EXT, 0: 1 enables 2-byte instruction lengths and 2-byte target alignment.
- REG_W, 5: register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  issue handshake valid.
- in_ready  out  1  issue handshake ready.
- in_op  in  instr_op  decoded op: INSTR_JAL/JALR/LUI/AUIPC/BEQ/BNE/BLT/BGE/BLTU/BGEU/INVAL.
- in_pc  in  XLEN  instruction PC.
- in_len2  in  1  instruction is 2 bytes (ignored when C_EXT=0).
- in_rs1_val, in_rs2_val  in  XLEN  operands.
- in_imm  in  XLEN  sign-extended immediate.
- in_rd  in  REG_W  destination index.
- out_valid  out  1  result handshake valid.
- out_ready  in  1  result handshake ready.
- out_rd_idx  out  REG_W  destination; 0 means no writeback.
- out_rd_val  out  XLEN  writeback value.
- out_br_valid  out  1  redirect required.
- out_br_target  out  XLEN  redirect PC.
- out_exc_valid  out  1  exception.
- out_exc_cause  out  2  0=none, 1=illegal instr, 2=target misaligned.

Behaviour:
- Reset (rst low, asynchronous): queue empty, count=0, rd/wr pointers=0, out_valid=0. All out_* data fields read 0 while empty. in_ready=1 after reset release.
- Accept: in_valid&&in_ready on a clock edge. Result computed combinationally and written to the tail; appears at head with out_valid=1 the next cycle. Latency 1 when the queue was empty.
- in_ready = (count<DEPTH) || out_ready. Simultaneous push+pop when full is legal; count unchanged.
- Pop: out_valid&&out_ready. Queue is FIFO; pointers wrap mod DEPTH. Output fields are stable while out_valid&&!out_ready.
- ilen = (C_EXT && in_len2) ? 2 : 4. link = in_pc+ilen. Sums wrap modulo 2^XLEN.
- JAL: target=pc+imm, br_valid=1, rd_val=link.
- JALR: target=(rs1+imm)&~1, br_valid=1, rd_val=link.
- LUI: rd_val=imm, br_valid=0.
- AUIPC: rd_val=pc+imm, br_valid=0.
- Branches: target=pc+imm, rd_idx forced 0. Condition: BEQ/BNE equality; BLT/BGE signed compare; BLTU/BGEU unsigned compare.
  - Taken: br_valid=1.
  - Not taken: br_valid=0, br_target=link.
- Misaligned: if the redirect would occur and target[1]=1 with C_EXT=0, then exc cause 2, br_valid=0, rd_idx=0.
- INVAL: exc cause 1, br_valid=0, rd_idx=0, rd_val=0, br_target=pc.
- Any exception forces rd_idx=0; exc_valid = (cause!=0).
- Flush (synchronous, highest priority): empties the queue the next cycle. An input accepted in the same cycle is discarded; a pop in the same cycle is still counted as completed by the consumer. in_ready stays unaffected.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

Test Plan:
- JALR with pc=0x100, rs1=0x2001, imm=4, rd=1, C_EXT=0, out_ready=1 -> next cycle: out_valid=1, rd_idx=1, rd_val=0x104, br_valid=1, br_target=0x2004, exc_valid=0.
- BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x40, imm=-8 -> br_valid=1, target=0x38, rd_idx=0. BLTU with the same operands -> br_valid=0, br_target=0x44.
- Backpressure, DEPTH=2, out_ready=0, three back-to-back LUI (imm 0x1000, 0x2000, 0x3000) -> first two accepted, in_ready=0 on the third. Raise out_ready: results drain in order 0x1000, 0x2000; the third is accepted on the pop cycle and emerges last.
- JAL with pc=0x10, imm=0x6, C_EXT=0 -> exc_valid=1, cause=2, br_valid=0, rd_idx=0. Same stimulus with C_EXT=1 and in_len2=1 -> br_target=0x16, rd_val=0x12, no exception.
- INVAL at pc=0x80 -> cause=1, br_target=0x80, rd_idx=0.
- Flush and reset:
  - Two entries queued plus flush with a simultaneous valid input -> next cycle out_valid=0, count=0, and the input result never appears.
  - rst low mid-stream -> out_valid=0 immediately.
